// File: rtl/tank_pkg.sv
// Shared definitions for the tank input path.
// Holds the fire-control state encoding and the default timing and magazine
// constants. Other tank instances and the HUD logic use the same values.
package tank_pkg;

    typedef enum logic [1:0] {
        FS_READY    = 2'd0,
        FS_COOLDOWN = 2'd1,
        FS_RELOAD   = 2'd2
    } fire_state_t;

    localparam int unsigned DEF_COOLDOWN_CYCLES = 10_000_000;
    localparam int unsigned DEF_RELOAD_CYCLES   = 50_000_000;
    localparam int unsigned DEF_AMMO_MAX        = 5;
    localparam int unsigned DEF_AMMO_W          = 3;
    localparam int unsigned DEF_CNT_W           = 32;

endpackage

// File: rtl/fire_control.sv
// fire_control: converts a debounced fire-button level into single-cycle shot
// strobes. It enforces a cooldown after each shot, a finite magazine, and a
// timed reload. The reload starts automatically when the magazine is empty,
// or on request.
//
// Ports
//   clk        in   system clock
//   rst_n      in   asynchronous active-low reset
//   btn_level  in   debounced fire-button level (synchronous to clk)
//   reload_req in   debounced manual-reload level
//   enable     in   round active; low re-arms the block to a full magazine
//   fire_pulse out  one-cycle shot strobe (registered)
//   ammo       out  rounds remaining
//   ready      out  high while a shot can be accepted
//   reloading  out  high while a reload is in progress
module fire_control
    import tank_pkg::*;
#(
    parameter int unsigned COOLDOWN_CYCLES = DEF_COOLDOWN_CYCLES,
    parameter int unsigned RELOAD_CYCLES   = DEF_RELOAD_CYCLES,
    parameter int unsigned AMMO_MAX        = DEF_AMMO_MAX,
    parameter int unsigned AMMO_W          = DEF_AMMO_W,
    parameter int unsigned CNT_W           = DEF_CNT_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              btn_level,
    input  logic              reload_req,
    input  logic              enable,
    output logic              fire_pulse,
    output logic [AMMO_W-1:0] ammo,
    output logic              ready,
    output logic              reloading
);

    // Load values are one less than the dwell, because the timer counts down
    // through zero inclusive.
    localparam logic [CNT_W-1:0]  COOL_LOAD = CNT_W'(COOLDOWN_CYCLES - 1);
    localparam logic [CNT_W-1:0]  REL_LOAD  = CNT_W'(RELOAD_CYCLES - 1);
    localparam logic [AMMO_W-1:0] AMMO_FULL = AMMO_W'(AMMO_MAX);

    fire_state_t       r_state;
    logic [AMMO_W-1:0] r_ammo;
    logic [CNT_W-1:0]  r_timer;
    logic              r_fire_pulse;
    logic              r_btn_prev;
    logic              w_press;

    // r_btn_prev resets high, so a button held through reset release is not
    // seen as a press.
    assign w_press = btn_level & ~r_btn_prev;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= FS_READY;
            r_ammo       <= AMMO_FULL;
            r_timer      <= '0;
            r_fire_pulse <= 1'b0;
            r_btn_prev   <= 1'b1;
        end else begin
            r_btn_prev   <= btn_level;
            r_fire_pulse <= 1'b0;
            if (!enable) begin
                r_state <= FS_READY;
                r_ammo  <= AMMO_FULL;
                r_timer <= '0;
            end else begin
                case (r_state)
                    FS_READY: begin
                        // A shot takes priority over a reload request in the same cycle.
                        if (w_press && (r_ammo != '0)) begin
                            r_fire_pulse <= 1'b1;
                            r_ammo       <= r_ammo - AMMO_W'(1);
                            if (r_ammo == AMMO_W'(1)) begin
                                r_timer <= REL_LOAD;
                                r_state <= FS_RELOAD;
                            end else begin
                                r_timer <= COOL_LOAD;
                                r_state <= FS_COOLDOWN;
                            end
                        end else if (reload_req && (r_ammo < AMMO_FULL)) begin
                            r_timer <= REL_LOAD;
                            r_state <= FS_RELOAD;
                        end
                    end
                    FS_COOLDOWN: begin
                        if (r_timer == '0) begin
                            r_state <= FS_READY;
                        end else begin
                            r_timer <= r_timer - CNT_W'(1);
                        end
                    end
                    FS_RELOAD: begin
                        if (r_timer == '0) begin
                            r_ammo  <= AMMO_FULL;
                            r_state <= FS_READY;
                        end else begin
                            r_timer <= r_timer - CNT_W'(1);
                        end
                    end
                    default: begin
                        r_state <= FS_READY;
                        r_timer <= '0;
                    end
                endcase
            end
        end
    end

    assign fire_pulse = r_fire_pulse;
    assign ammo       = r_ammo;
    assign ready      = (r_state == FS_READY);
    assign reloading  = (r_state == FS_RELOAD);

endmodule

// File: doc/fire_control.md
Name: fire_control

Overview:
- Sits directly downstream of the fire-button debouncer in each tank's input path.
- Turns the debounced fire level into single-cycle shot pulses for the projectile spawner.
- Enforces a per-shot cooldown, a finite magazine and a timed reload (automatic when empty, or on request).
- Exposes ammo count and status to the HUD/score logic.

Parameters:
- COOLDOWN_CYCLES, 10_000_000, cycles between an accepted shot and the next acceptable press (>=1).
- RELOAD_CYCLES, 50_000_000, duration of a reload in cycles (>=1).
- AMMO_MAX, 5, magazine size (>=1, < 2**AMMO_W).
- AMMO_W, 3, width of ammo output.
- CNT_W, 32, timer width; must hold max(COOLDOWN_CYCLES, RELOAD_CYCLES)-1.

Ports:
- clk  in  1  system clock; single clock domain.
- rst_n  in  1  asynchronous, active-low reset.
- btn_level  in  1  debounced fire-button level, synchronous to clk.
- reload_req  in  1  debounced manual-reload level; acts as a level request.
- enable  in  1  round active; low means the round is inactive and re-arms the block.
- fire_pulse  out  1  one-cycle shot strobe, registered.
- ammo  out  AMMO_W  rounds remaining.
- ready  out  1  high when in READY (which implies ammo>0).
- reloading  out  1  high when in RELOAD.

Behaviour:
- Reset (async, rst_n=0): state=READY, ammo=AMMO_MAX, timer=0, fire_pulse=0, btn_prev=1.
  - btn_prev=1 means a button held through reset release does not fire.
- btn_prev <= btn_level every cycle in all states; press = btn_level & ~btn_prev.
- Presses are never queued. The button must be released and re-pressed after cooldown or reload ends.
- fire_pulse defaults to 0 every cycle and is high for exactly one cycle per accepted shot.
- enable=0 (synchronous, overrides all states):
  - state=READY, ammo=AMMO_MAX, timer=0, fire_pulse=0.
  - btn_prev still tracks btn_level.
- READY, enable=1:
  - press and ammo>0: on this edge fire_pulse<=1 (visible the cycle after the press is sampled) and ammo<=ammo-1.
    - If the new ammo is 0: timer<=RELOAD_CYCLES-1, go RELOAD.
    - Otherwise: timer<=COOLDOWN_CYCLES-1, go COOLDOWN.
  - else if reload_req=1 and ammo<AMMO_MAX: timer<=RELOAD_CYCLES-1, go RELOAD.
  - A press and reload_req in the same cycle: the shot wins and reload_req is ignored that cycle.
  - reload_req with a full magazine: ignored.
- COOLDOWN:
  - Presses and reload_req are ignored.
  - timer decrements each cycle; when timer==0, go READY.
  - Total dwell is exactly COOLDOWN_CYCLES cycles.
- RELOAD:
  - Presses are ignored.
  - timer decrements each cycle; when timer==0, set ammo<=AMMO_MAX and go READY.
  - Total dwell is exactly RELOAD_CYCLES cycles.
- Status outputs are registered or decoded from state registers only, with no combinational path from inputs:
  - ready = (state==READY)
  - reloading = (state==RELOAD)
- Timer never wraps: it only decrements when non-zero in COOLDOWN or RELOAD.
- ammo never underflows: a shot requires ammo>0, and READY with ammo==0 is unreachable.
- Reset asserted mid-cooldown or mid-reload returns immediately to reset values.

Decomposition:
- Shared package tank_pkg:
  - fire-state encoding constants: READY=2'd0, COOLDOWN=2'd1, RELOAD=2'd2.
  - default timing constants, so other tanks' instances and the HUD share them.
- No sub-module is required. The press edge detector is two lines and is kept inline.
- The single loadable down-counter is shared by COOLDOWN and RELOAD.

Test Plan:
All scenarios use COOLDOWN_CYCLES=4, RELOAD_CYCLES=6, AMMO_MAX=3, enable=1 unless stated.
- Single shot: btn_level 0->1 held 20 cycles -> exactly one fire_pulse one cycle after the press sample; ammo 3->2; ready low for exactly 4 cycles.
- Cooldown drop: fire, release, re-press 2 cycles later and hold -> no second pulse. Release and press after ready returns -> second pulse, ammo=1.
- Auto reload: three spaced shots -> ammo 0 and reloading=1 for exactly 6 cycles. Presses during reload produce no pulse. After reload, ammo=3 and ready=1.
- Manual reload:
  - with ammo=2, assert reload_req -> RELOAD for 6 cycles, then ammo=3.
  - with ammo=3, reload_req has no effect.
  - press and reload_req in the same cycle -> shot taken, ammo=1, state COOLDOWN.
- Reset/enable:
  - hold btn_level=1 through rst_n release -> no pulse.
  - drop enable mid-reload -> next cycle ready=1, ammo=3, reloading=0.
  - assert rst_n=0 mid-cooldown -> outputs at reset values without waiting for a clock edge.
